// File: rtl/calc_display_scan.sv
// Purpose : scanned N-digit seven-segment driver for the calculator number format.
// Latency : every output is registered, one cycle behind the scan state and active buffer.
// Backpr. : none; load_i is always accepted, and the last load before a frame boundary wins.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   load_i              one-cycle strobe capturing error_i/sign_i/exponent_i/significand_i
//   error_i, sign_i     number is an error / number is negative
//   exponent_i          digits right of the decimal point
//   significand_i       packed BCD, digit 0 in bits [3:0] (rightmost)
//   seg_o, dp_o         segments {top,ur,lr,bottom,ll,ul,middle} and decimal point
//   digit_en_o          one-hot digit enable, all inactive during the blank interval
//   neg_o               active-buffer sign (suppressed for errors)
//   frame_o             one-cycle pulse in the cycle after a frame boundary
module calc_display_scan #(
   parameter int NumDigits    = 8,
   parameter int ScanCycles   = 1024,
   parameter int BlankCycles  = 16,
   parameter int SegActiveLow = 0
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          load_i,
   input  logic                          error_i,
   input  logic                          sign_i,
   input  logic [$clog2(NumDigits)-1:0]  exponent_i,
   input  logic [NumDigits*4-1:0]        significand_i,
   output logic [6:0]                    seg_o,
   output logic                          dp_o,
   output logic [NumDigits-1:0]          digit_en_o,
   output logic                          neg_o,
   output logic                          frame_o
);

   localparam int IW = $clog2(NumDigits);
   localparam int CW = $clog2(ScanCycles);
   localparam logic [CW-1:0] CNT_LAST = CW'(ScanCycles - 1);
   localparam logic [CW-1:0] BLANK_W  = CW'(BlankCycles);
   localparam logic [IW-1:0] IDX_LAST = IW'(NumDigits - 1);
   localparam logic          INV      = (SegActiveLow != 0);

   localparam logic [6:0] GLYPH_E     = 7'b1001111;
   localparam logic [6:0] GLYPH_MINUS = 7'b0000001;

   // Scan state
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic          boundary;

   // Staging and active number buffers
   logic                   pending;
   logic                   stg_err, stg_sign;
   logic [IW-1:0]          stg_exp;
   logic [NumDigits*4-1:0] stg_sig;
   logic                   act_err, act_sign;
   logic [IW-1:0]          act_exp;
   logic [NumDigits*4-1:0] act_sig;

   // Rendering of the digit selected by idx
   logic [NumDigits-1:0] upper_zero;
   logic [IW-1:0]        msd, msd_p;
   logic                 minus_here;
   logic [3:0]           dig;
   logic [6:0]           seg_d;
   logic                 dp_d;
   logic                 in_blank;
   logic                 zero_run;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'b1111110;
         4'd1:    g = 7'b0110000;
         4'd2:    g = 7'b1101101;
         4'd3:    g = 7'b1111001;
         4'd4:    g = 7'b0110011;
         4'd5:    g = 7'b1011011;
         4'd6:    g = 7'b1011111;
         4'd7:    g = 7'b1110000;
         4'd8:    g = 7'b1111111;
         4'd9:    g = 7'b1111011;
         default: g = 7'b0000000;
      endcase
      return g;
   endfunction

   assign boundary = (cnt == CNT_LAST) && (idx == IDX_LAST);
   assign in_blank = (cnt < BLANK_W);

   always_comb begin
      upper_zero = '0;
      zero_run   = 1'b1;
      msd        = '0;
      // upper_zero[i]: digits NumDigits-1 down to i are all zero
      for (int i = NumDigits - 1; i >= 0; i--) begin
         zero_run      = zero_run && (act_sig[i*4 +: 4] == 4'd0);
         upper_zero[i] = zero_run;
      end
      for (int i = 0; i < NumDigits; i++) begin
         if (act_sig[i*4 +: 4] != 4'd0) begin
            msd = IW'(i);
         end
      end
      // The minus glyph sits left of whichever is further left: the MSD or the
      // digit carrying the decimal point (so "-0.07" keeps its leading zero).
      msd_p      = (act_exp > msd) ? act_exp : msd;
      minus_here = act_sign && !act_err && (msd_p != IDX_LAST) && (idx == msd_p + 1'b1);
      dig        = act_sig[{idx, 2'b00} +: 4];

      if (act_err) begin
         seg_d = (idx == '0) ? GLYPH_E : 7'b0000000;
      end else if (minus_here) begin
         seg_d = GLYPH_MINUS;
      end else if ((idx > act_exp) && upper_zero[idx]) begin
         seg_d = 7'b0000000;
      end else begin
         seg_d = glyph(dig);
      end
      dp_d = !act_err && (act_exp != '0) && (idx == act_exp);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt        <= '0;
         idx        <= '0;
         pending    <= 1'b0;
         stg_err    <= 1'b0;
         stg_sign   <= 1'b0;
         stg_exp    <= '0;
         stg_sig    <= '0;
         act_err    <= 1'b0;
         act_sign   <= 1'b0;
         act_exp    <= '0;
         act_sig    <= '0;
         seg_o      <= {7{INV}};
         dp_o       <= INV;
         digit_en_o <= {NumDigits{INV}};
         neg_o      <= 1'b0;
         frame_o    <= 1'b0;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end

         if (load_i) begin
            stg_err  <= error_i;
            stg_sign <= sign_i;
            stg_exp  <= exponent_i;
            stg_sig  <= significand_i;
         end

         // Active only changes at the frame boundary; a load landing exactly
         // on the boundary bypasses staging so it is not delayed a whole frame.
         if (boundary) begin
            if (load_i) begin
               act_err  <= error_i;
               act_sign <= sign_i;
               act_exp  <= exponent_i;
               act_sig  <= significand_i;
            end else if (pending) begin
               act_err  <= stg_err;
               act_sign <= stg_sign;
               act_exp  <= stg_exp;
               act_sig  <= stg_sig;
            end
            pending <= 1'b0;
         end else if (load_i) begin
            pending <= 1'b1;
         end

         if (in_blank) begin
            seg_o      <= {7{INV}};
            dp_o       <= INV;
            digit_en_o <= {NumDigits{INV}};
         end else begin
            seg_o      <= seg_d ^ {7{INV}};
            dp_o       <= dp_d ^ INV;
            digit_en_o <= (NumDigits'(1) << idx) ^ {NumDigits{INV}};
         end
         neg_o   <= act_sign && !act_err;
         frame_o <= boundary;
      end
   end

endmodule
